// File: rtl/rom_dl_router.sv
// ROM-download front end: splits the HPS ioctl stream into programmable address
// windows (SDRAM toggle handshake or BRAM strobe), captures core_mod/DIP bytes, drives core reset.
module rom_dl_router #(
    parameter int                     NREG    = 4,
    parameter int                     AW      = 25,
    parameter logic [NREG*AW-1:0]     BASE    = {(NREG*AW){1'b0}},
    parameter logic [NREG*AW-1:0]     LIMIT   = {(NREG*AW){1'b0}},
    parameter logic [NREG-1:0]        ACKMASK = {NREG{1'b1}},
    parameter int                     DIPN    = 8,
    parameter int                     RSTW    = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [AW-1:0]        ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic                 ioctl_wait,
    input  logic                 user_reset,
    output logic [NREG-1:0]      win_req,
    input  logic [NREG-1:0]      win_ack,
    output logic [NREG-1:0]      win_we,
    output logic [NREG*AW-1:0]   win_addr,
    output logic [7:0]           win_d,
    output logic [1:0]           win_ds,
    output logic [7:0]           core_mod,
    output logic [8*DIPN-1:0]    dip_flat,
    output logic                 rom_loaded,
    output logic                 core_reset,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              wr_d_r;
    logic              rom_dl_d_r;
    logic [AW-1:0]     lat_addr_r;
    logic [7:0]        lat_d_r;
    logic [NREG-1:0]   lat_hit_r;
    logic [RSTW-1:0]   cnt_r;

    logic              rom_dl_s;
    logic              wr_edge_s;
    logic              ev_rom_s;
    logic              ev_mod_s;
    logic              ev_dip_s;
    logic [NREG-1:0]   hit_s;
    logic [NREG-1:0]   acked_s;
    logic              ready_s;
    logic              latch_s;
    logic              issue_s;

    assign rom_dl_s   = ioctl_download & (ioctl_index == 8'd0);
    assign wr_edge_s  = ioctl_wr & ~wr_d_r;
    assign ev_rom_s   = rom_dl_s & wr_edge_s;
    assign ev_mod_s   = ioctl_download & (ioctl_index == 8'd1) & wr_edge_s;
    assign ev_dip_s   = ioctl_download & (ioctl_index == 8'd254) & wr_edge_s
                        & (ioctl_addr < AW'(DIPN));
    // Only windows that wait on the SDRAM side gate progress; the registered req is the reference.
    assign acked_s    = lat_hit_r & ACKMASK;
    assign ready_s    = ((win_req ^ win_ack) & acked_s) == {NREG{1'b0}};
    assign ioctl_wait = (state_r != IDLE);

    // Window decode of the live address
    always_comb begin
        hit_s = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            hit_s[i] = (ioctl_addr >= BASE[i*AW +: AW]) && (ioctl_addr < LIMIT[i*AW +: AW]);
        end
    end

    // FSM state register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and latch/issue controls
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        issue_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (ev_rom_s && (hit_s != {NREG{1'b0}})) begin
                    latch_s     = 1'b1;
                    state_nxt_s = PEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PEND: begin
                if (ready_s) begin
                    issue_s     = 1'b1;
                    state_nxt_s = (acked_s != {NREG{1'b0}}) ? BUSY : IDLE;
                end else begin
                    state_nxt_s = PEND;
                end
            end
            BUSY: begin
                if (ready_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Write capture, window issue and overrun tracking
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_d_r     <= 1'b0;
            lat_addr_r <= {AW{1'b0}};
            lat_d_r    <= 8'd0;
            lat_hit_r  <= {NREG{1'b0}};
            win_req    <= {NREG{1'b0}};
            win_we     <= {NREG{1'b0}};
            win_addr   <= {(NREG*AW){1'b0}};
            win_d      <= 8'd0;
            win_ds     <= 2'b00;
            overrun    <= 1'b0;
        end else begin
            wr_d_r <= ioctl_wr;
            win_we <= {NREG{1'b0}};
            if (latch_s) begin
                lat_addr_r <= ioctl_addr;
                lat_d_r    <= ioctl_dout;
                lat_hit_r  <= hit_s;
            end
            if (issue_s) begin
                win_req <= win_req ^ lat_hit_r;
                win_we  <= lat_hit_r;
                win_d   <= lat_d_r;
                win_ds  <= {lat_addr_r[0], ~lat_addr_r[0]};
                for (int i = 0; i < NREG; i++) begin
                    if (lat_hit_r[i]) begin
                        win_addr[i*AW +: AW] <= lat_addr_r - BASE[i*AW +: AW];
                    end
                end
            end
            if (ev_rom_s && (state_r != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // core_mod and DIP byte capture
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            core_mod <= 8'd0;
            dip_flat <= {(8*DIPN){1'b0}};
        end else begin
            if (ev_mod_s) begin
                core_mod <= ioctl_dout;
            end
            if (ev_dip_s) begin
                for (int k = 0; k < DIPN; k++) begin
                    if (ioctl_addr == AW'(k)) begin
                        dip_flat[8*k +: 8] <= ioctl_dout;
                    end
                end
            end
        end
    end

    // rom_loaded follows the ROM download edges; a new download revokes it
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_dl_d_r <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            rom_dl_d_r <= rom_dl_s;
            if (rom_dl_s && !rom_dl_d_r) begin
                rom_loaded <= 1'b0;
            end else if (!rom_dl_s && rom_dl_d_r) begin
                rom_loaded <= 1'b1;
            end else begin
                rom_loaded <= rom_loaded;
            end
        end
    end

    // Core reset hold counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_r      <= {RSTW{1'b1}};
            core_reset <= 1'b1;
        end else begin
            if (user_reset || !rom_loaded) begin
                cnt_r <= {RSTW{1'b1}};
            end else if (cnt_r != {RSTW{1'b0}}) begin
                cnt_r <= cnt_r - RSTW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            core_reset <= (cnt_r != {RSTW{1'b0}});
        end
    end

endmodule

// File: tb/tb_rom_dl_router.sv
// Self-checking bench for rom_dl_router: vector table, hand-written corner sequences and
// randomized ROM writes checked against a window-arithmetic reference model.
module tb_rom_dl_router;

    localparam int NREG = 4;
    localparam int AW   = 25;
    localparam int DIPN = 8;
    localparam int RSTW = 4;

    localparam logic [NREG*AW-1:0] P_BASE  = {25'h50000, 25'h90000, 25'h30000, 25'h00000};
    localparam logic [NREG*AW-1:0] P_LIMIT = {25'h40000, 25'hA0000, 25'h90000, 25'h90000};
    localparam logic [NREG-1:0]    P_ACK   = 4'b0011;

    localparam logic [AW-1:0] M_BASE  [NREG] = '{25'h00000, 25'h30000, 25'h90000, 25'h50000};
    localparam logic [AW-1:0] M_LIMIT [NREG] = '{25'h90000, 25'h90000, 25'hA0000, 25'h40000};

    logic                clk_sys = 1'b0;
    logic                reset;
    logic                ioctl_download;
    logic [7:0]          ioctl_index;
    logic                ioctl_wr;
    logic [AW-1:0]       ioctl_addr;
    logic [7:0]          ioctl_dout;
    logic                ioctl_wait;
    logic                user_reset;
    logic [NREG-1:0]     win_req;
    logic [NREG-1:0]     win_ack;
    logic [NREG-1:0]     win_we;
    logic [NREG*AW-1:0]  win_addr;
    logic [7:0]          win_d;
    logic [1:0]          win_ds;
    logic [7:0]          core_mod;
    logic [8*DIPN-1:0]   dip_flat;
    logic                rom_loaded;
    logic                core_reset;
    logic                overrun;

    rom_dl_router #(
        .NREG(NREG), .AW(AW), .BASE(P_BASE), .LIMIT(P_LIMIT),
        .ACKMASK(P_ACK), .DIPN(DIPN), .RSTW(RSTW)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .user_reset(user_reset),
        .win_req(win_req), .win_ack(win_ack), .win_we(win_we), .win_addr(win_addr),
        .win_d(win_d), .win_ds(win_ds), .core_mod(core_mod), .dip_flat(dip_flat),
        .rom_loaded(rom_loaded), .core_reset(core_reset), .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors = 0;
    int errors  = 0;
    int we_count = 0;
    logic [NREG-1:0] exp_req = 4'b0000;

    // SDRAM side: echo each req toggle after ack_dly cycles unless held
    logic [NREG-1:0] ack_r;
    logic [NREG-1:0] ack_hold = 4'b0000;
    int              ack_dly  = 5;
    int              dly_cnt [NREG];
    assign win_ack = ack_r;

    always @(posedge clk_sys) begin
        if (reset) begin
            ack_r <= 4'b0000;
            for (int i = 0; i < NREG; i++) dly_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if ((win_req[i] != ack_r[i]) && !ack_hold[i]) begin
                    if (dly_cnt[i] >= ack_dly) begin
                        ack_r[i]   <= win_req[i];
                        dly_cnt[i] <= 0;
                    end else begin
                        dly_cnt[i] <= dly_cnt[i] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        if (win_we != 4'b0000) we_count <= we_count + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wait"},   64'(ioctl_wait), 64'(1'b0));
        chk({tag, "_req"},    64'(win_req), 64'(4'b0000));
        chk({tag, "_we"},     64'(win_we), 64'(4'b0000));
        chk({tag, "_addr"},   64'(win_addr == {(NREG*AW){1'b0}}), 64'(1'b1));
        chk({tag, "_d"},      64'(win_d), 64'(8'h00));
        chk({tag, "_ds"},     64'(win_ds), 64'(2'b00));
        chk({tag, "_mod"},    64'(core_mod), 64'(8'h00));
        chk({tag, "_dip"},    dip_flat, 64'h0);
        chk({tag, "_loaded"}, 64'(rom_loaded), 64'(1'b0));
        chk({tag, "_ovr"},    64'(overrun), 64'(1'b0));
        chk({tag, "_corerst"}, 64'(core_reset), 64'(1'b1));
    endtask

    task automatic pulse_wr(input logic [AW-1:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
        @(negedge clk_sys);
    endtask

    // One ROM write with its expected window effect, waited through to idle
    task automatic rom_write(input logic [AW-1:0] a, input logic [7:0] d, input logic [NREG-1:0] ehit,
                             input logic [1:0] eds, input logic [NREG*AW-1:0] erel);
        int   c;
        int   we0;
        logic got;
        we0 = we_count;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
        chk("wait_on_accept", 64'(ioctl_wait), 64'(ehit != 4'b0000));
        if (ehit == 4'b0000) begin
            repeat (4) @(negedge clk_sys);
            chk("miss_no_we", 64'(we_count - we0), 64'(0));
            chk("miss_wait", 64'(ioctl_wait), 64'(1'b0));
        end else begin
            got = 1'b0;
            c   = 0;
            while (!got && c < 60) begin
                if (win_we != 4'b0000) got = 1'b1;
                else begin
                    @(negedge clk_sys);
                    c++;
                end
            end
            chk("issue_seen", 64'(got), 64'(1'b1));
            chk("win_we", 64'(win_we), 64'(ehit));
            exp_req = exp_req ^ ehit;
            chk("win_req", 64'(win_req), 64'(exp_req));
            chk("win_d", 64'(win_d), 64'(d));
            chk("win_ds", 64'(win_ds), 64'(eds));
            for (int i = 0; i < NREG; i++) begin
                if (ehit[i]) chk($sformatf("win_addr%0d", i), 64'(win_addr[i*AW +: AW]), 64'(erel[i*AW +: AW]));
            end
            chk("wait_at_issue", 64'(ioctl_wait), 64'((ehit & P_ACK) != 4'b0000));
            c = 0;
            while (ioctl_wait && c < 200) begin
                @(negedge clk_sys);
                c++;
            end
            chk("idle_reached", 64'(ioctl_wait), 64'(1'b0));
            chk("acks_settled", 64'((win_req ^ win_ack) & ehit & P_ACK), 64'(4'b0000));
            @(negedge clk_sys);
            chk("we_one_cycle", 64'(win_we), 64'(4'b0000));
            chk("we_pulses", 64'(we_count - we0), 64'(1));
        end
    endtask

    typedef struct {
        logic [AW-1:0]      addr;
        logic [7:0]         data;
        logic [NREG-1:0]    hit;
        logic [1:0]         ds;
        logic [NREG*AW-1:0] rel;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [AW-1:0]      a;
        logic [7:0]         d;
        logic [NREG-1:0]    ehit;
        logic [NREG*AW-1:0] erel;
        int                 c;
        int                 we0;
        logic               got;

        tbl[0] = '{25'h31235, 8'hAB, 4'b0011, 2'b10, {25'h0, 25'h0, 25'h01235, 25'h31235}};
        tbl[1] = '{25'h90010, 8'h5A, 4'b0100, 2'b01, {25'h0, 25'h00010, 25'h0, 25'h0}};
        tbl[2] = '{25'h2FFFF, 8'h11, 4'b0001, 2'b10, {25'h0, 25'h0, 25'h0, 25'h2FFFF}};
        tbl[3] = '{25'h30000, 8'h22, 4'b0011, 2'b01, {25'h0, 25'h0, 25'h00000, 25'h30000}};
        tbl[4] = '{25'h8FFFF, 8'h33, 4'b0011, 2'b10, {25'h0, 25'h0, 25'h5FFFF, 25'h8FFFF}};
        tbl[5] = '{25'h9FFFF, 8'h44, 4'b0100, 2'b10, {25'h0, 25'h0FFFF, 25'h0, 25'h0}};
        tbl[6] = '{25'hA0000, 8'h55, 4'b0000, 2'b00, {(NREG*AW){1'b0}}};
        tbl[7] = '{25'h45000, 8'h66, 4'b0011, 2'b01, {25'h0, 25'h0, 25'h15000, 25'h45000}};
        tbl[8] = '{25'h00000, 8'h77, 4'b0001, 2'b01, {25'h0, 25'h0, 25'h0, 25'h00000}};

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'h0;
        ioctl_dout     = 8'h00;
        user_reset     = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk_reset_vals("rst");
        reset = 1'b0;

        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        @(negedge clk_sys);

        ack_dly = 5;
        for (int v = 0; v < 9; v++) begin
            rom_write(tbl[v].addr, tbl[v].data, tbl[v].hit, tbl[v].ds, tbl[v].rel);
        end

        // Second write edge while BUSY with acks held: dropped, overrun sticks
        ack_hold = 4'b0011;
        ack_dly  = 0;
        we0 = we_count;
        ioctl_addr = 25'h40000;
        ioctl_dout = 8'h77;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        got = 1'b0;
        c   = 0;
        while (!got && c < 60) begin
            if (win_we != 4'b0000) got = 1'b1;
            else begin
                @(negedge clk_sys);
                c++;
            end
        end
        chk("ovr_issue_seen", 64'(got), 64'(1'b1));
        chk("ovr_we", 64'(win_we), 64'(4'b0011));
        exp_req = exp_req ^ 4'b0011;
        ioctl_addr = 25'h50000;
        ioctl_dout = 8'h99;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("ovr_flag", 64'(overrun), 64'(1'b1));
        repeat (3) @(negedge clk_sys);
        chk("ovr_wait_held", 64'(ioctl_wait), 64'(1'b1));
        ack_hold = 4'b0000;
        c = 0;
        while (ioctl_wait && c < 200) begin
            @(negedge clk_sys);
            c++;
        end
        chk("ovr_idle", 64'(ioctl_wait), 64'(1'b0));
        repeat (3) @(negedge clk_sys);
        chk("ovr_single_we", 64'(we_count - we0), 64'(1));
        chk("ovr_data_kept", 64'(win_d), 64'(8'h77));
        chk("ovr_req", 64'(win_req), 64'(exp_req));

        // Randomized writes against the window model
        for (int n = 0; n < 40; n++) begin
            a    = 25'($urandom_range(0, 32'h000AFFFF));
            d    = 8'($urandom);
            ehit = 4'b0000;
            erel = {(NREG*AW){1'b0}};
            for (int i = 0; i < NREG; i++) begin
                if ((a >= M_BASE[i]) && (a < M_LIMIT[i])) begin
                    ehit[i] = 1'b1;
                    erel[i*AW +: AW] = a - M_BASE[i];
                end
            end
            ack_dly = $urandom_range(0, 6);
            rom_write(a, d, ehit, {a[0], ~a[0]}, erel);
            repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        end
        chk("ovr_sticky", 64'(overrun), 64'(1'b1));
        chk("dl_not_loaded", 64'(rom_loaded), 64'(1'b0));
        chk("dl_core_rst", 64'(core_reset), 64'(1'b1));

        // End of ROM download: rom_loaded, then 16-cycle core reset release
        ioctl_download = 1'b0;
        chk("loaded_pre_edge", 64'(rom_loaded), 64'(1'b0));
        @(negedge clk_sys);
        chk("loaded_set", 64'(rom_loaded), 64'(1'b1));
        chk("corerst_at_load", 64'(core_reset), 64'(1'b1));
        repeat (15) @(negedge clk_sys);
        chk("corerst_15", 64'(core_reset), 64'(1'b1));
        @(negedge clk_sys);
        chk("corerst_16", 64'(core_reset), 64'(1'b0));

        // DIP and core_mod capture
        ioctl_download = 1'b1;
        ioctl_index    = 8'd254;
        we0 = we_count;
        pulse_wr(25'h00001, 8'h3C);
        pulse_wr(25'h00009, 8'hFF);
        pulse_wr(25'h00008, 8'hEE);
        pulse_wr(25'h00007, 8'h77);
        pulse_wr(25'h31235, 8'h55);
        chk("dip_flat", dip_flat, 64'h7700_0000_0000_3C00);
        ioctl_index = 8'd1;
        pulse_wr(25'h00000, 8'h21);
        pulse_wr(25'h31235, 8'h0B);
        chk("core_mod", 64'(core_mod), 64'(8'h0B));
        chk("side_no_we", 64'(we_count - we0), 64'(0));
        chk("side_no_wait", 64'(ioctl_wait), 64'(1'b0));
        chk("side_req", 64'(win_req), 64'(exp_req));
        chk("side_loaded", 64'(rom_loaded), 64'(1'b1));
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        @(negedge clk_sys);

        // User reset pulse
        chk("cr_low_before_user", 64'(core_reset), 64'(1'b0));
        user_reset = 1'b1;
        @(negedge clk_sys);
        user_reset = 1'b0;
        @(negedge clk_sys);
        chk("user_rst_assert", 64'(core_reset), 64'(1'b1));
        repeat (14) @(negedge clk_sys);
        chk("user_rst_15", 64'(core_reset), 64'(1'b1));
        @(negedge clk_sys);
        chk("user_rst_16", 64'(core_reset), 64'(1'b0));

        // Re-download revokes rom_loaded and re-asserts core reset
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        @(negedge clk_sys);
        chk("redl_loaded", 64'(rom_loaded), 64'(1'b0));
        repeat (2) @(negedge clk_sys);
        chk("redl_core_rst", 64'(core_reset), 64'(1'b1));

        // Reset while a write is pending
        we0 = we_count;
        ioctl_addr = 25'h31235;
        ioctl_dout = 8'hC3;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("pend_before_reset", 64'(ioctl_wait), 64'(1'b1));
        reset = 1'b1;
        @(negedge clk_sys);
        chk_reset_vals("pendrst");
        reset   = 1'b0;
        exp_req = 4'b0000;
        repeat (5) @(negedge clk_sys);
        chk("pendrst_no_we", 64'(we_count - we0), 64'(0));
        chk("pendrst_idle", 64'(ioctl_wait), 64'(1'b0));
        chk("pendrst_req", 64'(win_req), 64'(exp_req));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rom_dl_router.md
Name: rom_dl_router

Overview:
- Generalised ROM-download front end for arcade cores.
- Decodes the HPS ioctl download stream into NREG programmable address windows. Each window drives one SDRAM-port toggle handshake or one BRAM write strobe.
- Applies backpressure (ioctl_wait) while SDRAM acks are outstanding.
- Captures the core_mod byte (index 1) and DIP bytes (index 254).
- Generates the core reset: held while ROM is not loaded, on user reset, and again on every re-download.

Parameters:
- NREG, 4: number of address windows.
- AW, 25: ioctl address width.
- BASE, {NREG{25'h0}}: packed window base addresses, window i at [i*AW +: AW].
- LIMIT, {NREG{25'h0}}: packed exclusive window ends. LIMIT_i <= BASE_i disables window i.
- ACKMASK, {NREG{1'b1}}: per-window flag; 1 = SDRAM toggle handshake waited on, 0 = fire-and-forget.
- DIPN, 8: number of DIP bytes captured.
- RSTW, 16: width of the reset hold counter.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- ioctl_download, in, 1: download active.
- ioctl_index, in, 8: download index.
- ioctl_wr, in, 1: byte write (level; rising edge is the event).
- ioctl_addr, in, AW: byte address.
- ioctl_dout, in, 8: byte data.
- ioctl_wait, out, 1: backpressure to hps_io.
- user_reset, in, 1: status[0] | buttons[1].
- win_req, out, NREG: per-window request toggle.
- win_ack, in, NREG: per-window ack toggle (SDRAM side).
- win_we, out, NREG: one-cycle write strobe per window.
- win_addr, out, NREG*AW: per-window relative address (addr - BASE_i), registered.
- win_d, out, 8: captured data byte.
- win_ds, out, 2: byte lane {addr[0], ~addr[0]}.
- core_mod, out, 8: last byte written at index 1.
- dip_flat, out, 8*DIPN: DIP bytes, byte k at [8k +: 8].
- rom_loaded, out, 1: ROM download completed since reset.
- core_reset, out, 1: reset to the game core.
- overrun, out, 1: sticky flag; a write edge was dropped.

Behaviour:
- Event definition: rom_dl = ioctl_download & (ioctl_index==0). A write event is a rising edge of ioctl_wr, detected against a registered copy of ioctl_wr.
- Hit vector: hit_i = (addr >= BASE_i) & (addr < LIMIT_i), comparisons unsigned. Overlapping windows all hit. An event with hit == 0 is ignored.
- State machine, states IDLE / PEND / BUSY:
  - IDLE: on a rom_dl event with hit != 0, latch addr, data, lanes and hit; go to PEND.
  - PEND: wait until req_i == ack_i for every latched i with ACKMASK_i. Then, in one cycle: toggle win_req_i for all latched i, pulse win_we_i for one cycle, present win_addr/win_d/win_ds. Go to BUSY, or to IDLE if no latched window has ACKMASK set.
  - BUSY: when req_i == ack_i for every latched acked window, go to IDLE.
- win_addr/win_d/win_ds hold their value until the next issue.
- ioctl_wait = (state != IDLE), combinational from the state register.
- Fire-and-forget windows never stall. A write edge arriving while state != IDLE is dropped and sets overrun. overrun clears only on reset.
- An issue and an ack can happen in the same cycle; compare against the registered req.
- Index 1 write event: core_mod <= ioctl_dout, regardless of address.
- Index 254 write event with addr < DIPN: dip byte[addr] <= ioctl_dout. Any other address is ignored.
- Index 1 and index 254 writes never touch the windows or the FSM.
- rom_loaded:
  - Set on the cycle after the falling edge of rom_dl.
  - Cleared on the rising edge of rom_dl, so a re-download re-asserts core reset.
- Reset counter (RSTW bits):
  - Loaded with all-ones when reset | user_reset | ~rom_loaded.
  - Otherwise decrements to 0 and saturates.
  - core_reset <= (cnt != 0), registered. Deassertion is 2^RSTW-1 cycles plus 1 after the last reset cause.
- Reset values:
  - win_req = 0, win_we = 0, win_addr = 0, win_d = 0, win_ds = 0.
  - ioctl_wait = 0, state = IDLE, core_mod = 0, dip = 0, rom_loaded = 0, overrun = 0, core_reset = 1, cnt = all-ones.
- Reset during PEND or BUSY drops the pending write. The SDRAM side is reset with the same reset, so its acks restart at 0.

Test Plan:
1. BASE={0,0x30000}, LIMIT={0x90000,0x90000}, both windows acked. Write 0x31235=0xAB, ack after 5 cycles → both req toggle in the same cycle; win_addr0=0x31235, win_addr1=0x1235; win_ds=2'b10; ioctl_wait high until both acks, then low.
2. Window 2 [0x20000,0x30000) with ACKMASK=0; write 0x20010=0x5A → single win_we[2] pulse, win_addr2=0x10, ioctl_wait high for 1 cycle, req2 toggles without stalling.
3. Hold ack, then raise a second ioctl_wr edge during BUSY → second write dropped, overrun=1, state returns to IDLE after the ack.
4. Index 254: write addr 1=0x3C, then addr 9=0xFF → dip_flat[15:8]=0x3C; all other DIP bytes stay 0. Index 1 write 0x0B → core_mod=0x0B.
5. RSTW=4: complete download; core_reset falls 16 cycles after rom_loaded rises. Pulse user_reset → core_reset re-asserts next cycle. Start a new download → rom_loaded=0, core_reset=1.
6. Assert reset while in PEND → state IDLE, win_req=0, ioctl_wait=0 next cycle, no win_we pulse.
